// File: rtl/banked_ram_pkg.sv
// Shared definitions for the banked RAM: bank-select width helper, default sizes, request record.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package bank_ram_pkg;

    localparam int DEF_NUM_BANKS  = 4;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_NUM_PORTS  = 2;

    // Low address bits that pick the bank; at least one bit so vectors never go zero-width.
    function automatic int bank_sel_bits(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    // One requester's command in the default configuration.
    typedef struct packed {
        logic                          we;
        logic [DEF_ADDR_WIDTH-1:0]     addr;
        logic [DEF_DATA_WIDTH-1:0]     wdata;
        logic [DEF_DATA_WIDTH/8-1:0]   be;
    } req_t;

endpackage

// File: rtl/banked_ram_if.sv
// Request/response bundle between requesters (master) and the banked RAM (slave).
// Latency: wires only.
// Backpressure: req_ready per port; responses are never stalled.
// Ports: req_valid/req_ready/req_we/req_addr/req_wdata/req_be per port; rsp_valid/rsp_rdata per port.
interface banked_ram_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
);
    logic [NUM_PORTS-1:0]                    req_valid;
    logic [NUM_PORTS-1:0]                    req_ready;
    logic [NUM_PORTS-1:0]                    req_we;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]    req_addr;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    req_wdata;
    logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]  req_be;
    logic [NUM_PORTS-1:0]                    rsp_valid;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/bank_sp_ram.sv
// Single-port storage bank with per-byte write enables and a registered read port.
// Latency: read data valid one cycle after an enabled read; writes land at the enabling edge.
// Backpressure: none; accepts one access per cycle when en is high.
// Ports: clk; en/we/row/wdata/be access strobe and command; rdata registered read result.
module bank_sp_ram #(
    parameter int ROW_WIDTH  = 8,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [ROW_WIDTH-1:0]    row,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   rdata
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ROW_WIDTH;

    // Contents are deliberately left unreset: unwritten rows read back as X.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Read register only moves on a read so it holds between accesses.
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[row];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (en && we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[row][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/banked_ram.sv
// Multi-port RAM built from address-interleaved single-port banks with per-bank round-robin arbitration.
// Latency: read response exactly one cycle after acceptance; writes produce no response.
// Backpressure: req_ready drops for ports losing a bank conflict; responses cannot be stalled.
// Ports: clk, rst (async, active-high); bus (slave modport of banked_ram_if) carries requests and responses.
module banked_ram
    import bank_ram_pkg::*;
#(
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PORTS  = 2
) (
    input  logic        clk,
    input  logic        rst,
    banked_ram_if.slave bus
);
    localparam int BANK_W = bank_sel_bits(NUM_BANKS);
    localparam int ROW_W  = ADDR_WIDTH - BANK_W;
    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_BANKS-1:0][PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0]                 grant;

    logic [NUM_BANKS-1:0]                 bank_en;
    logic [NUM_BANKS-1:0]                 bank_we;
    logic [NUM_BANKS-1:0][ROW_W-1:0]      bank_row;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_wdata;
    logic [NUM_BANKS-1:0][BE_W-1:0]       bank_be;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata;

    // Read tag: which bank each port's pending response comes from.
    logic [NUM_PORTS-1:0]                 rsp_vld_q, rsp_vld_d;
    logic [NUM_PORTS-1:0][BANK_W-1:0]     rsp_bank_q, rsp_bank_d;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rsp_hold_q, rsp_hold_d;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rsp_rdata;

    // Per bank: scan ports starting at the pointer; first hit wins. The pointer only
    // advances past the winner when someone else also wanted the bank.
    always_comb begin
        int   n_req;
        int   win;
        int   idx;
        logic found;

        grant      = '0;
        rr_ptr_d   = rr_ptr_q;
        bank_en    = '0;
        bank_we    = '0;
        bank_row   = '0;
        bank_wdata = '0;
        bank_be    = '0;
        n_req      = 0;
        win        = 0;
        idx        = 0;
        found      = 1'b0;

        for (int b = 0; b < NUM_BANKS; b++) begin
            n_req = 0;
            win   = 0;
            found = 1'b0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = int'(rr_ptr_q[b]) + k;
                if (idx >= NUM_PORTS) begin
                    idx = idx - NUM_PORTS;
                end
                if (bus.req_valid[idx] && (bus.req_addr[idx][BANK_W-1:0] == BANK_W'(b))) begin
                    n_req = n_req + 1;
                    if (!found) begin
                        found = 1'b1;
                        win   = idx;
                    end
                end
            end
            if (found && !rst) begin
                grant[win]    = 1'b1;
                bank_en[b]    = 1'b1;
                bank_we[b]    = bus.req_we[win];
                bank_row[b]   = bus.req_addr[win][ADDR_WIDTH-1:BANK_W];
                bank_wdata[b] = bus.req_wdata[win];
                bank_be[b]    = bus.req_be[win];
                if (n_req > 1) begin
                    rr_ptr_d[b] = (win + 1 == NUM_PORTS) ? '0 : PTR_W'(win + 1);
                end
            end
        end
    end

    assign bus.req_ready = grant;

    // Response steering: live bank data while the tag is valid, otherwise the last value.
    always_comb begin
        rsp_vld_d  = '0;
        rsp_bank_d = rsp_bank_q;
        rsp_rdata  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rsp_vld_d[p] = grant[p] && !bus.req_we[p];
            if (rsp_vld_d[p]) begin
                rsp_bank_d[p] = bus.req_addr[p][BANK_W-1:0];
            end
            rsp_rdata[p] = rsp_vld_q[p] ? bank_rdata[rsp_bank_q[p]] : rsp_hold_q[p];
        end
        rsp_hold_d = rsp_rdata;
    end

    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_rdata = rsp_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            rsp_vld_q  <= '0;
            rsp_bank_q <= '0;
            rsp_hold_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_bank_q <= rsp_bank_d;
            rsp_hold_q <= rsp_hold_d;
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        bank_sp_ram #(
            .ROW_WIDTH  (ROW_W),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en[g]),
            .we    (bank_we[g]),
            .row   (bank_row[g]),
            .wdata (bank_wdata[g]),
            .be    (bank_be[g]),
            .rdata (bank_rdata[g])
        );
    end
endmodule

// File: tb/tb_banked_ram.sv
// Self-checking bench for banked_ram: directed scenarios plus random traffic against a word-array model.
// Latency: model expects read data one cycle after acceptance.
// Backpressure: requesters hold their command until the model says it was granted.
module tb_banked_ram;
    import bank_ram_pkg::*;

    localparam int NP  = 2;
    localparam int NB  = 4;
    localparam int AW  = 10;
    localparam int DW  = 64;
    localparam int BEW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    banked_ram_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    banked_ram #(
        .NUM_BANKS  (NB),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_PORTS  (NP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: flat word array with per-byte "ever written" flags.
    logic [DW-1:0]  m_dat   [1<<AW];
    logic [BEW-1:0] m_known [1<<AW];
    int             m_rr    [NB];
    logic [NP-1:0]  m_rsp_vld;
    logic [DW-1:0]  m_rsp_dat [NP];
    logic [DW-1:0]  m_rsp_msk [NP];

    req_t          pend   [NP];
    bit            pend_v [NP];
    logic [NP-1:0] acc;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] bytes_to_bits(input logic [BEW-1:0] be);
        logic [DW-1:0] r;
        for (int i = 0; i < BEW; i++) r[i*8 +: 8] = {8{be[i]}};
        return r;
    endfunction

    task automatic drive(input int p);
        bus.req_valid[p] = pend_v[p];
        bus.req_we[p]    = pend[p].we;
        bus.req_addr[p]  = pend[p].addr;
        bus.req_wdata[p] = pend[p].wdata;
        bus.req_be[p]    = pend[p].be;
    endtask

    task automatic set_req(input int p, input bit v, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BEW-1:0] be);
        pend_v[p]      = v;
        pend[p].we     = we;
        pend[p].addr   = a;
        pend[p].wdata  = d;
        pend[p].be     = be;
        drive(p);
    endtask

    task automatic model_reset();
        m_rsp_vld = '0;
        for (int p = 0; p < NP; p++) begin
            m_rsp_dat[p] = '0;
            m_rsp_msk[p] = '1;
        end
        for (int b = 0; b < NB; b++) m_rr[b] = 0;
    endtask

    // One clock: check outputs at the falling edge, advance the model, return at rise + 1.
    task automatic step(output logic [NP-1:0] accepted);
        logic [NP-1:0] exp_rdy;
        int first, n, p, a;
        @(negedge clk);
        exp_rdy = '0;
        if (!rst) begin
            for (int b = 0; b < NB; b++) begin
                first = -1;
                n     = 0;
                for (int k = 0; k < NP; k++) begin
                    p = (m_rr[b] + k) % NP;
                    if (bus.req_valid[p] && (int'(bus.req_addr[p]) % NB) == b) begin
                        n++;
                        if (first < 0) first = p;
                    end
                end
                if (first >= 0) begin
                    exp_rdy[first] = 1'b1;
                    if (n > 1) m_rr[b] = (first + 1) % NP;
                end
            end
        end
        check_eq("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        check_eq("rsp_valid", 64'(bus.rsp_valid), 64'(m_rsp_vld));
        for (int q = 0; q < NP; q++) begin
            check_eq($sformatf("rsp_rdata%0d", q), bus.rsp_rdata[q] & m_rsp_msk[q],
                     m_rsp_dat[q] & m_rsp_msk[q]);
        end
        m_rsp_vld = '0;
        for (int q = 0; q < NP; q++) begin
            if (exp_rdy[q]) begin
                a = int'(bus.req_addr[q]);
                if (bus.req_we[q]) begin
                    for (int i = 0; i < BEW; i++) begin
                        if (bus.req_be[q][i]) begin
                            m_dat[a][i*8 +: 8] = bus.req_wdata[q][i*8 +: 8];
                            m_known[a][i]      = 1'b1;
                        end
                    end
                end else begin
                    m_rsp_vld[q] = 1'b1;
                    m_rsp_dat[q] = m_dat[a];
                    m_rsp_msk[q] = bytes_to_bits(m_known[a]);
                end
            end
        end
        accepted = exp_rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        logic [NP-1:0] dummy;
        idle_all();
        rst = 1'b1;
        #1;
        model_reset();
        step(dummy);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [BEW-1:0] rbe;
        int             sel;

        for (int i = 0; i < (1 << AW); i++) m_known[i] = '0;
        rst = 1'b0;
        idle_all();
        model_reset();
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst_ready", 64'(bus.req_ready), 64'd0);
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("rst_rdata0", bus.rsp_rdata[0], 64'd0);
        check_eq("rst_rdata1", bus.rsp_rdata[1], 64'd0);
        // A request presented during reset must not be accepted.
        set_req(0, 1'b1, 1'b0, 10'h004, '0, '0);
        step(acc);
        step(acc);
        idle_all();
        rst = 1'b0;

        // Write then read-after-write of the same word.
        set_req(0, 1'b1, 1'b1, 10'h004, 64'h1122334455667788, 8'hFF);
        step(acc);
        set_req(0, 1'b1, 1'b0, 10'h004, '0, '0);
        step(acc);
        check_eq("raw_vld", 64'(bus.rsp_valid[0]), 64'd1);
        check_eq("raw_dat", bus.rsp_rdata[0], 64'h1122334455667788);
        idle_all();
        step(acc);
        check_eq("raw_hold", bus.rsp_rdata[0], 64'h1122334455667788);

        // Two ports, two distinct banks, same cycle.
        set_req(0, 1'b1, 1'b0, 10'h001, '0, '0);
        set_req(1, 1'b1, 1'b0, 10'h002, '0, '0);
        #1;
        check_eq("dual_ready", 64'(bus.req_ready), 64'd3);
        step(acc);
        check_eq("dual_vld", 64'(bus.rsp_valid), 64'd3);
        idle_all();
        step(acc);

        // Continuous contention for bank 0 alternates grants.
        do_reset();
        set_req(0, 1'b1, 1'b0, 10'h008, '0, '0);
        set_req(1, 1'b1, 1'b0, 10'h00C, '0, '0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("rr_grant%0d", i), 64'(bus.req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
            step(acc);
        end
        idle_all();
        step(acc);

        // Partial byte enables.
        set_req(0, 1'b1, 1'b1, 10'h010, '1, 8'hFF);
        step(acc);
        set_req(0, 1'b1, 1'b1, 10'h010, '0, 8'h0F);
        step(acc);
        set_req(0, 1'b1, 1'b0, 10'h010, '0, '0);
        step(acc);
        check_eq("be_partial", bus.rsp_rdata[0], 64'hFFFFFFFF00000000);
        idle_all();

        // All-zero byte enables leave the word alone.
        set_req(1, 1'b1, 1'b1, 10'h020, 64'hA5A50123456789AB, 8'hFF);
        step(acc);
        set_req(1, 1'b1, 1'b1, 10'h020, 64'hDEADBEEFDEADBEEF, 8'h00);
        step(acc);
        set_req(1, 1'b1, 1'b0, 10'h020, '0, '0);
        step(acc);
        check_eq("be_zero", bus.rsp_rdata[1], 64'hA5A50123456789AB);
        idle_all();
        step(acc);

        // Reset in flight drops the response and clears the pointer.
        do_reset();
        set_req(0, 1'b1, 1'b0, 10'h008, '0, '0);
        set_req(1, 1'b1, 1'b0, 10'h00C, '0, '0);
        step(acc);
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        check_eq("rstf_p1_alone", 64'(bus.req_ready), 64'd2);
        step(acc);
        check_eq("rstf_vld_before", 64'(bus.rsp_valid), 64'd2);
        rst = 1'b1;
        #1;
        check_eq("rstf_vld_cleared", 64'(bus.rsp_valid), 64'd0);
        model_reset();
        idle_all();
        step(acc);
        rst = 1'b0;
        set_req(1, 1'b1, 1'b0, 10'h00C, '0, '0);
        set_req(0, 1'b1, 1'b0, 10'h004, '0, '0);
        #1;
        check_eq("rstf_p0_first", 64'(bus.req_ready), 64'd1);
        step(acc);
        idle_all();
        step(acc);

        // Random traffic in a small address window to force bank conflicts.
        for (int c = 0; c < 800; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pend_v[p] && $urandom_range(0, 3) != 0) begin
                    sel = int'($urandom_range(0, 5));
                    rbe = (sel < 3) ? 8'hFF : (sel < 5) ? BEW'($urandom) : 8'h00;
                    set_req(p, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                            {$urandom, $urandom}, rbe);
                end else begin
                    drive(p);
                end
            end
            step(acc);
            for (int p = 0; p < NP; p++) begin
                if (acc[p]) pend_v[p] = 1'b0;
            end
        end
        idle_all();
        step(acc);
        step(acc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/banked_ram.md
BANKED_RAM -- requirements
Module: banked_ram

Interface
REQ-001 The module SHALL have parameter NUM_BANKS, default 4: number of address-interleaved banks (power of two, >=2).
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 10: word address width across all banks.
REQ-003 The module SHALL have parameter DATA_WIDTH, default 64: word width (multiple of 8).
REQ-004 The module SHALL have parameter NUM_PORTS, default 2: number of independent requesters.
REQ-005 Port clk SHALL be input, width 1: the single clock; all state updates on posedge.
REQ-006 Port rst SHALL be input, width 1: asynchronous, active-high reset.
REQ-007 Port req_valid SHALL be input [NUM_PORTS]: per-port request present.
REQ-008 Port req_ready SHALL be output [NUM_PORTS]: request accepted this cycle.
REQ-009 Port req_we SHALL be input [NUM_PORTS]: 1 = write, 0 = read.
REQ-010 Port req_addr SHALL be input [NUM_PORTS][ADDR_WIDTH]: word address.
REQ-011 Port req_wdata SHALL be input [NUM_PORTS][DATA_WIDTH]: write data.
REQ-012 Port req_be SHALL be input [NUM_PORTS][DATA_WIDTH/8]: byte write enables.
REQ-013 Port rsp_valid SHALL be output [NUM_PORTS]: read data valid.
REQ-014 Port rsp_rdata SHALL be output [NUM_PORTS][DATA_WIDTH]: read data.

Function
REQ-015 Bank index SHALL be req_addr[log2(NUM_BANKS)-1:0] and row SHALL be the remaining upper bits; each bank SHALL hold 2^ADDR_WIDTH/NUM_BANKS words.
REQ-016 A request SHALL be accepted when req_valid && req_ready are both high at a clock edge; req_ready SHALL be combinational from req_valid, req_addr and arbiter state only.
REQ-017 Requests from different ports to distinct banks SHALL all be accepted in the same cycle.
REQ-018 When two or more ports target one bank, exactly one SHALL be granted, using a per-bank round-robin pointer.
REQ-019 The round-robin pointer SHALL be 0 after reset, SHALL become (granted port + 1) mod NUM_PORTS after a contested grant, and SHALL NOT change on an uncontested grant.
REQ-020 Losing ports SHALL see req_ready=0; the requester SHALL hold req_* stable until accepted.
REQ-021 An accepted write SHALL update each byte i with req_be[i]=1 at the acceptance edge, leave bytes with req_be[i]=0 unchanged, and produce no response.
REQ-022 An accepted write with req_be all-zero SHALL leave memory unchanged and still consume the bank grant.
REQ-023 An accepted read SHALL produce rsp_valid=1 on the same port exactly 1 cycle later, with rsp_rdata equal to the row content at the acceptance edge.
REQ-024 rsp_valid SHALL be 0 in any cycle not preceded by an accepted read on that port, and rsp_rdata SHALL hold its last value while rsp_valid=0.
REQ-025 Reads SHALL be fully pipelined: back-to-back reads from one port to one bank SHALL yield one result per cycle.
REQ-026 A write accepted at edge N followed by a read of the same address accepted at edge N+1 SHALL return the written data.

Reset
REQ-027 While rst=1, req_ready, rsp_valid and rsp_rdata SHALL all be 0 and all round-robin pointers SHALL be 0.
REQ-028 Memory contents SHALL NOT be reset; a read of a never-written row SHALL return undefined data (X in simulation).
REQ-029 Asserting rst between read acceptance and response SHALL clear rsp_valid immediately and drop the read; normal acceptance SHALL resume at the first edge after rst deasserts.

Structure
REQ-030 Package bank_ram_pkg SHALL hold the bank-select width function/localparams and a request typedef (we, addr, wdata, be).
REQ-031 Storage SHALL be in one sub-module, bank_sp_ram: single-port, byte-enable, 1-cycle registered read, instantiated NUM_BANKS times via generate.
REQ-032 Arbitration and response routing (a 1-stage per-port read tag register) SHALL reside in banked_ram.

Verification
REQ-033 Port0 write 0x004, data 0x1122334455667788, be 0xFF; next cycle port0 read 0x004 -> rsp_valid[0]=1 one cycle later, rdata 0x1122334455667788.
REQ-034 Port0 read 0x001 and port1 read 0x002 in the same cycle -> req_ready=2'b11, both rsp_valid high the next cycle.
REQ-035 Both ports continuously request bank 0 (0x008, 0x00C) for 4 cycles after reset -> grants port0, port1, port0, port1.
REQ-036 Write 0x010 = all-ones with be 0xFF, then write 0x0 with be 0x0F, then read 0x010 -> 0xFFFFFFFF00000000.
REQ-037 Write 0x020 with be 0x00, then read 0x020 -> prior content unchanged.
REQ-038 Assert rst the cycle after a read is accepted -> rsp_valid=0 immediately; after release, port1/port0 contest one bank -> port0 is granted first.
